// File: rtl/palette_loader.sv
// palette_loader: DMA engine that copies R,G,B palette entries from main
// memory into the 256-entry palette, one channel write per fetched byte.
// Software programs SRC / START_IDX / COUNT, then writes START to CMD.
module palette_loader #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_BUS_WIDTH   = 19,
  parameter int PIXEL_ADDR_WIDTH = 8,
  parameter logic [ADDR_BUS_WIDTH-1:0] CTRL_BASE = 19'h00408
) (
  input  logic                        cpu_clock,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       data_bus,
  input  logic [ADDR_BUS_WIDTH-1:0]   addr_bus,
  input  logic                        data_wen,
  output logic                        mem_req,
  output logic [ADDR_BUS_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  input  logic                        mem_rvalid,
  output logic                        pal_wen,
  output logic [1:0]                  pal_chan,
  output logic [PIXEL_ADDR_WIDTH-1:0] pal_index,
  output logic [3:0]                  pal_data,
  output logic                        busy,
  output logic                        done
);

  // Remaining-entry counter is one bit wider so COUNT=0 can mean 256.
  localparam int CNT_W = PIXEL_ADDR_WIDTH + 1;

  localparam logic [ADDR_BUS_WIDTH-1:0] A_SRC0  = CTRL_BASE;
  localparam logic [ADDR_BUS_WIDTH-1:0] A_SRC1  = CTRL_BASE + ADDR_BUS_WIDTH'(1);
  localparam logic [ADDR_BUS_WIDTH-1:0] A_SRC2  = CTRL_BASE + ADDR_BUS_WIDTH'(2);
  localparam logic [ADDR_BUS_WIDTH-1:0] A_START = CTRL_BASE + ADDR_BUS_WIDTH'(3);
  localparam logic [ADDR_BUS_WIDTH-1:0] A_COUNT = CTRL_BASE + ADDR_BUS_WIDTH'(4);
  localparam logic [ADDR_BUS_WIDTH-1:0] A_CMD   = CTRL_BASE + ADDR_BUS_WIDTH'(5);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Programmed (software-visible) registers.
  logic [ADDR_BUS_WIDTH-1:0]   src;
  logic [PIXEL_ADDR_WIDTH-1:0] start_idx;
  logic [PIXEL_ADDR_WIDTH-1:0] count;

  // Working copies used while a transfer runs.
  logic [ADDR_BUS_WIDTH-1:0]   addr;
  logic [PIXEL_ADDR_WIDTH-1:0] idx;
  logic [CNT_W-1:0]            remaining;
  logic [1:0]                  chan;

  logic idle;
  logic cfg_wen;
  logic cmd_hit;
  logic start_go;
  logic abort_go;
  logic last_write;
  logic [CNT_W-1:0] cnt_load;

  // Only the low nibble of each fetched byte is a colour value.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[DATA_WIDTH-1:4];

  assign idle       = (state_q == S_IDLE);
  assign cfg_wen    = data_wen && idle;
  assign cmd_hit    = data_wen && (addr_bus == A_CMD);
  // ABORT takes priority over a START written in the same command.
  assign abort_go   = cmd_hit && data_bus[1];
  assign start_go   = cmd_hit && data_bus[0] && !data_bus[1] && idle;
  assign last_write = (chan == 2'd2) && (remaining == CNT_W'(1));
  assign cnt_load   = (count == '0) ? CNT_W'(1 << PIXEL_ADDR_WIDTH)
                                    : {1'b0, count};

  // Configuration registers; frozen while a transfer is in flight.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      src       <= '0;
      start_idx <= '0;
      count     <= '0;
    end else if (cfg_wen) begin
      if (addr_bus == A_SRC0)  src[7:0]  <= data_bus[7:0];
      if (addr_bus == A_SRC1)  src[15:8] <= data_bus[7:0];
      if (addr_bus == A_SRC2)  src[ADDR_BUS_WIDTH-1:16] <= data_bus[ADDR_BUS_WIDTH-17:0];
      if (addr_bus == A_START) start_idx <= data_bus[PIXEL_ADDR_WIDTH-1:0];
      if (addr_bus == A_COUNT) count     <= data_bus[PIXEL_ADDR_WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge cpu_clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and combinational outputs.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_addr = addr;
    pal_wen  = 1'b0;
    busy     = !idle;
    unique case (state_q)
      S_IDLE: if (start_go) state_d = S_REQ;
      S_REQ: begin
        mem_req = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (mem_rvalid) state_d = S_WR;
      S_WR: begin
        pal_wen = 1'b1;
        state_d = last_write ? S_IDLE : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_go) state_d = S_IDLE;
  end

  // Working address/index/channel/count, done flag and palette write port.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      addr      <= '0;
      idx       <= '0;
      remaining <= '0;
      chan      <= '0;
      done      <= 1'b0;
      pal_chan  <= '0;
      pal_index <= '0;
      pal_data  <= '0;
    end else begin
      if (start_go) begin
        addr      <= src;
        idx       <= start_idx;
        remaining <= cnt_load;
        chan      <= 2'd0;
        done      <= 1'b0;
      end
      // Palette port fields are loaded only when a write is about to issue,
      // so they hold between pulses.
      if (state_q == S_WAIT && mem_rvalid && !abort_go) begin
        pal_chan  <= chan;
        pal_index <= idx;
        pal_data  <= mem_rdata[3:0];
      end
      if (state_q == S_WR && !abort_go) begin
        addr <= addr + ADDR_BUS_WIDTH'(1);
        if (chan != 2'd2) begin
          chan <= chan + 2'd1;
        end else begin
          chan      <= 2'd0;
          idx       <= idx + PIXEL_ADDR_WIDTH'(1);
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) done <= 1'b1;
        end
      end
    end
  end

endmodule
